// File: rtl/branch_predict_unit_pkg.sv
// Shared definitions for the branch predict unit.
// Holds the 2-bit direction counter encodings, helpers that derive the BTB
// index and tag widths from XLEN and BTB_ENTRIES, the saturating counter
// update, and a BTB entry layout for the default 32-bit / 16-entry build.
package bp_pkg;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_e;

  function automatic int idx_w(input int entries);
    return $clog2(entries);
  endfunction

  // The low two PC bits are never part of the index or the tag.
  function automatic int tag_w(input int xlen, input int entries);
    return xlen - $clog2(entries) - 2;
  endfunction

  // Saturating direction update: stays at ST when taken and at SNT when not.
  function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
    logic [1:0] res;
    res = ctr;
    if (taken && ctr != ST) res = ctr + 2'd1;
    if (!taken && ctr != SNT) res = ctr - 2'd1;
    return res;
  endfunction

  localparam int DEF_XLEN    = 32;
  localparam int DEF_ENTRIES = 16;
  localparam int DEF_TAG_W   = DEF_XLEN - $clog2(DEF_ENTRIES) - 2;

  // Entry layout for the default configuration. The top level declares the
  // same field order with widths taken from its own parameters.
  typedef struct packed {
    logic                  valid;
    logic [DEF_TAG_W-1:0]  tag;
    logic [DEF_XLEN-2:0]   target;
    logic [1:0]            ctr;
    logic                  is_jump;
  } bp_entry_t;

endpackage

// File: rtl/branch_predict_unit_if.sv
// Fetch / execute / redirect bundle of the branch predict unit.
// master: the pipeline side (drives fetch_pc and the resolve fields, consumes
//         the prediction, redirect and flush).
// slave : the branch predict unit itself.
interface branch_predict_unit_if #(
  parameter int XLEN = 32
);
  import bp_pkg::*;

  logic [XLEN-1:0] fetch_pc;
  logic            pred_taken;
  logic [XLEN-1:0] pred_target;

  logic            resolve_valid;
  logic [XLEN-1:0] resolve_pc;
  logic            resolve_is_branch;
  logic            resolve_is_jump;
  logic            resolve_taken;
  logic [XLEN-1:0] resolve_target;
  logic            resolve_pred_taken;
  logic [XLEN-1:0] resolve_pred_target;

  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            flush;

  modport master (
    output fetch_pc, resolve_valid, resolve_pc, resolve_is_branch, resolve_is_jump,
           resolve_taken, resolve_target, resolve_pred_taken, resolve_pred_target,
    input  pred_taken, pred_target, redirect_valid, redirect_pc, flush
  );

  modport slave (
    input  fetch_pc, resolve_valid, resolve_pc, resolve_is_branch, resolve_is_jump,
           resolve_taken, resolve_target, resolve_pred_taken, resolve_pred_target,
    output pred_taken, pred_target, redirect_valid, redirect_pc, flush
  );
endinterface

// File: rtl/branch_predict_unit_btb.sv
// Direct-mapped BTB storage.
// Ports:
//   clk, rst            clock and synchronous active-high reset (loads RST_WORD everywhere)
//   rd_a_idx/rd_a_data  asynchronous read port (fetch lookup)
//   rd_b_idx/rd_b_data  asynchronous read port (resolve-side lookup for training)
//   wr_en/wr_idx/wr_data synchronous write port
// Reads return the stored contents, so a read of the index being written
// sees the old entry until the clock edge.
module bp_btb
  import bp_pkg::*;
#(
  parameter int                ENTRIES  = 16,
  parameter int                WIDTH    = 8,
  parameter logic [WIDTH-1:0]  RST_WORD = '0,
  localparam int               IDX_W    = idx_w(ENTRIES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_a_idx,
  output logic [WIDTH-1:0] rd_a_data,
  input  logic [IDX_W-1:0] rd_b_idx,
  output logic [WIDTH-1:0] rd_b_data,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [WIDTH-1:0] wr_data
);

  logic [WIDTH-1:0] mem [ENTRIES];

  assign rd_a_data = mem[rd_a_idx];
  assign rd_b_data = mem[rd_b_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) mem[i] <= RST_WORD;
    end else if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

endmodule

// File: rtl/branch_predict_unit.sv
// Branch predict unit: BTB lookup for fetch, training from execute-stage
// resolution, registered redirect plus multi-cycle flush on mispredict, and
// saturating performance counters.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   stall             freezes training, counters and mispredict detection
//   bus (slave)       fetch lookup, resolve inputs, redirect and flush outputs
//   branch_count      resolved branches plus jumps (saturating)
//   mispredict_count  mispredicts (saturating)
module branch_predict_unit
  import bp_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int BTB_ENTRIES  = 16,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  branch_predict_unit_if.slave bus,
  output logic [CNT_W-1:0]     branch_count,
  output logic [CNT_W-1:0]     mispredict_count
);

  localparam int IDX_W = idx_w(BTB_ENTRIES);
  localparam int TAG_W = tag_w(XLEN, BTB_ENTRIES);
  localparam int FC_W  = $clog2(FLUSH_CYCLES + 1);

  localparam logic [0:0] IDLE     = 1'b0;
  localparam logic [0:0] FLUSHING = 1'b1;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [XLEN-2:0]  target;
    logic [1:0]       ctr;
    logic             is_jump;
  } entry_t;

  localparam int     ENTRY_W   = $bits(entry_t);
  localparam entry_t RST_ENTRY = '{valid: 1'b0, tag: '0, target: '0, ctr: WNT, is_jump: 1'b0};

  logic [IDX_W-1:0]   f_idx, r_idx;
  logic [TAG_W-1:0]   f_tag, r_tag;
  logic [ENTRY_W-1:0] f_raw, r_raw;
  entry_t             f_ent, r_ent, wr_ent;
  logic               f_hit, r_hit, wr_en;
  logic               pred_taken;

  logic               upd, is_jmp, is_br, alias_hit, mispredict;
  logic [XLEN-1:0]    tgt_al, pc_plus4, redir_next;

  logic [0:0]         state;
  logic [FC_W-1:0]    fcnt;
  logic               redirect_valid_q;
  logic [XLEN-1:0]    redirect_pc_q;

  assign f_idx = bus.fetch_pc[IDX_W+1:2];
  assign f_tag = bus.fetch_pc[XLEN-1:IDX_W+2];
  assign r_idx = bus.resolve_pc[IDX_W+1:2];
  assign r_tag = bus.resolve_pc[XLEN-1:IDX_W+2];

  bp_btb #(
    .ENTRIES  (BTB_ENTRIES),
    .WIDTH    (ENTRY_W),
    .RST_WORD (RST_ENTRY)
  ) u_btb (
    .clk       (clk),
    .rst       (rst),
    .rd_a_idx  (f_idx),
    .rd_a_data (f_raw),
    .rd_b_idx  (r_idx),
    .rd_b_data (r_raw),
    .wr_en     (wr_en),
    .wr_idx    (r_idx),
    .wr_data   (wr_ent)
  );

  assign f_ent = f_raw;
  assign r_ent = r_raw;

  // Fetch-side prediction: jumps always redirect, branches follow ctr[1].
  assign f_hit           = f_ent.valid && (f_ent.tag == f_tag);
  assign pred_taken      = f_hit && (f_ent.is_jump || f_ent.ctr[1]);
  assign bus.pred_taken  = pred_taken;
  assign bus.pred_target = pred_taken ? {f_ent.target, 1'b0} : bus.fetch_pc + XLEN'(4);

  // Resolve decode. Targets are halfword aligned, so bit 0 of the actual
  // target is dropped before any compare or store. A branch+jump combination
  // is handled as a jump.
  assign upd        = bus.resolve_valid && !stall;
  assign is_jmp     = bus.resolve_is_jump;
  assign is_br      = bus.resolve_is_branch && !bus.resolve_is_jump;
  assign tgt_al     = bus.resolve_target & ~XLEN'(1);
  assign pc_plus4   = bus.resolve_pc + XLEN'(4);
  assign r_hit      = r_ent.valid && (r_ent.tag == r_tag);
  assign alias_hit  = upd && !is_br && !is_jmp && bus.resolve_pred_taken;
  assign mispredict = upd && ((bus.resolve_pred_taken != bus.resolve_taken) ||
                              (bus.resolve_taken && (bus.resolve_pred_target != tgt_al)));
  assign redir_next = (!alias_hit && bus.resolve_taken) ? tgt_al : pc_plus4;

  // BTB training. The write always targets the resolving PC's index; a
  // non-control instruction that was predicted taken has aliased onto a BTB
  // entry, so that entry is dropped.
  always_comb begin
    wr_en  = 1'b0;
    wr_ent = r_ent;
    if (upd) begin
      if (is_jmp) begin
        wr_en  = 1'b1;
        wr_ent = '{valid: 1'b1, tag: r_tag, target: tgt_al[XLEN-1:1], ctr: ST, is_jump: 1'b1};
      end else if (is_br) begin
        if (r_hit) begin
          wr_en          = 1'b1;
          wr_ent.ctr     = ctr_next(r_ent.ctr, bus.resolve_taken);
          wr_ent.is_jump = 1'b0;
          if (bus.resolve_taken) wr_ent.target = tgt_al[XLEN-1:1];
        end else if (bus.resolve_taken) begin
          wr_en  = 1'b1;
          wr_ent = '{valid: 1'b1, tag: r_tag, target: tgt_al[XLEN-1:1], ctr: WT, is_jump: 1'b0};
        end
      end else if (bus.resolve_pred_taken) begin
        wr_en        = 1'b1;
        wr_ent.valid = 1'b0;
      end
    end
  end

  // Redirect and flush. A mispredict always (re)loads the flush counter, so
  // back-to-back mispredicts extend the flush and the newest redirect wins.
  // The countdown keeps running during a stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      fcnt             <= '0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
    end else begin
      redirect_valid_q <= mispredict;
      if (mispredict) begin
        redirect_pc_q <= redir_next;
        fcnt          <= FC_W'(FLUSH_CYCLES);
        state         <= FLUSHING;
      end else if (fcnt != '0) begin
        fcnt <= fcnt - FC_W'(1);
        if (fcnt == FC_W'(1)) state <= IDLE;
      end
    end
  end

  assign bus.redirect_valid = redirect_valid_q;
  assign bus.redirect_pc    = redirect_pc_q;
  assign bus.flush          = (state == FLUSHING);

  // Performance counters stick at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      branch_count     <= '0;
      mispredict_count <= '0;
    end else begin
      if (upd && (bus.resolve_is_branch || bus.resolve_is_jump) && branch_count != '1)
        branch_count <= branch_count + CNT_W'(1);
      if (mispredict && mispredict_count != '1)
        mispredict_count <= mispredict_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed testbench for branch_predict_unit.
// dut_a uses the default build; dut_b sees identical stimulus but has
// FLUSH_CYCLES=3 and 2-bit performance counters so that flush extension and
// counter saturation can be observed.
module tb_branch_predict_unit;

  logic        clk;
  logic        rst;
  logic        stall;
  logic [31:0] bc_a, mc_a;
  logic [1:0]  bc_b, mc_b;
  int          checks;
  int          errors;

  branch_predict_unit_if #(.XLEN(32)) bus_a ();
  branch_predict_unit_if #(.XLEN(32)) bus_b ();

  assign bus_b.fetch_pc            = bus_a.fetch_pc;
  assign bus_b.resolve_valid       = bus_a.resolve_valid;
  assign bus_b.resolve_pc          = bus_a.resolve_pc;
  assign bus_b.resolve_is_branch   = bus_a.resolve_is_branch;
  assign bus_b.resolve_is_jump     = bus_a.resolve_is_jump;
  assign bus_b.resolve_taken       = bus_a.resolve_taken;
  assign bus_b.resolve_target      = bus_a.resolve_target;
  assign bus_b.resolve_pred_taken  = bus_a.resolve_pred_taken;
  assign bus_b.resolve_pred_target = bus_a.resolve_pred_target;

  branch_predict_unit #(.XLEN(32), .BTB_ENTRIES(16), .FLUSH_CYCLES(2), .CNT_W(32)) dut_a (
    .clk              (clk),
    .rst              (rst),
    .stall            (stall),
    .bus              (bus_a),
    .branch_count     (bc_a),
    .mispredict_count (mc_a)
  );

  branch_predict_unit #(.XLEN(32), .BTB_ENTRIES(16), .FLUSH_CYCLES(3), .CNT_W(2)) dut_b (
    .clk              (clk),
    .rst              (rst),
    .stall            (stall),
    .bus              (bus_b),
    .branch_count     (bc_b),
    .mispredict_count (mc_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic applyStimulus(input logic is_br, input logic is_j, input logic [31:0] pc,
                               input logic taken, input logic [31:0] tgt,
                               input logic ptaken, input logic [31:0] ptgt);
    bus_a.resolve_valid       = 1'b1;
    bus_a.resolve_is_branch   = is_br;
    bus_a.resolve_is_jump     = is_j;
    bus_a.resolve_pc          = pc;
    bus_a.resolve_taken       = taken;
    bus_a.resolve_target      = tgt;
    bus_a.resolve_pred_taken  = ptaken;
    bus_a.resolve_pred_target = ptgt;
  endtask

  // One resolution presented for a single clock edge; afterwards the
  // registered redirect of that resolution is visible.
  task automatic resolveOne(input logic is_br, input logic is_j, input logic [31:0] pc,
                            input logic taken, input logic [31:0] tgt,
                            input logic ptaken, input logic [31:0] ptgt);
    applyStimulus(is_br, is_j, pc, taken, tgt, ptaken, ptgt);
    step();
    bus_a.resolve_valid = 1'b0;
  endtask

  task automatic lookup(input string tag, input logic [31:0] pc,
                        input logic exp_taken, input logic [31:0] exp_tgt);
    bus_a.fetch_pc = pc;
    #1;
    checkOutput({tag, "_taken"}, 64'(bus_a.pred_taken), 64'(exp_taken));
    checkOutput({tag, "_target"}, 64'(bus_a.pred_target), 64'(exp_tgt));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    stall  = 1'b0;
    bus_a.fetch_pc = 32'h0;
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    bus_a.resolve_valid = 1'b0;
    idle(2);
    rst = 1'b0;

    $display("[TB] reset state");
    lookup("rst_lookup", 32'h100, 1'b0, 32'h104);
    checkOutput("rst_bc", 64'(bc_a), 64'd0);
    checkOutput("rst_mc", 64'(mc_a), 64'd0);
    checkOutput("rst_redirect_valid", 64'(bus_a.redirect_valid), 64'd0);
    checkOutput("rst_flush", 64'(bus_a.flush), 64'd0);

    $display("[TB] taken branch allocates");
    applyStimulus(1'b1, 1'b0, 32'h100, 1'b1, 32'h80, 1'b0, 32'h0);
    bus_a.fetch_pc = 32'h100;
    #1;
    checkOutput("alloc_same_cycle_lookup", 64'(bus_a.pred_taken), 64'd0);
    step();
    bus_a.resolve_valid = 1'b0;
    checkOutput("alloc_redirect_valid", 64'(bus_a.redirect_valid), 64'd1);
    checkOutput("alloc_redirect_pc", 64'(bus_a.redirect_pc), 64'h80);
    checkOutput("alloc_flush_c1", 64'(bus_a.flush), 64'd1);
    checkOutput("alloc_mc", 64'(mc_a), 64'd1);
    checkOutput("alloc_bc", 64'(bc_a), 64'd1);
    step();
    checkOutput("alloc_redirect_pulse", 64'(bus_a.redirect_valid), 64'd0);
    checkOutput("alloc_flush_c2", 64'(bus_a.flush), 64'd1);
    step();
    checkOutput("alloc_flush_end", 64'(bus_a.flush), 64'd0);
    lookup("alloc_hit", 32'h100, 1'b1, 32'h80);
    lookup("alloc_other_tag", 32'h140, 1'b0, 32'h144);
    idle(2);

    $display("[TB] not-taken training");
    resolveOne(1'b1, 1'b0, 32'h100, 1'b0, 32'h0, 1'b1, 32'h80);
    checkOutput("nt1_redirect_valid", 64'(bus_a.redirect_valid), 64'd1);
    checkOutput("nt1_redirect_pc", 64'(bus_a.redirect_pc), 64'h104);
    checkOutput("nt1_mc", 64'(mc_a), 64'd2);
    idle(3);
    lookup("nt1_ctr01", 32'h100, 1'b0, 32'h104);
    resolveOne(1'b1, 1'b0, 32'h100, 1'b0, 32'h0, 1'b0, 32'h104);
    checkOutput("nt2_redirect_valid", 64'(bus_a.redirect_valid), 64'd0);
    resolveOne(1'b1, 1'b0, 32'h100, 1'b0, 32'h0, 1'b0, 32'h104);
    checkOutput("nt3_redirect_valid", 64'(bus_a.redirect_valid), 64'd0);
    checkOutput("nt3_mc", 64'(mc_a), 64'd2);
    checkOutput("nt3_bc", 64'(bc_a), 64'd4);
    lookup("nt3_ctr_sat", 32'h100, 1'b0, 32'h104);
    idle(2);

    $display("[TB] jump entry");
    resolveOne(1'b0, 1'b1, 32'h200, 1'b1, 32'h400, 1'b0, 32'h0);
    checkOutput("jal_redirect_valid", 64'(bus_a.redirect_valid), 64'd1);
    checkOutput("jal_redirect_pc", 64'(bus_a.redirect_pc), 64'h400);
    checkOutput("jal_mc", 64'(mc_a), 64'd3);
    checkOutput("jal_bc", 64'(bc_a), 64'd5);
    idle(3);
    lookup("jal_hit", 32'h200, 1'b1, 32'h400);
    lookup("jal_evicted", 32'h100, 1'b0, 32'h104);
    resolveOne(1'b0, 1'b1, 32'h200, 1'b1, 32'h401, 1'b1, 32'h400);
    checkOutput("jal_repeat_redirect", 64'(bus_a.redirect_valid), 64'd0);
    checkOutput("jal_repeat_mc", 64'(mc_a), 64'd3);
    checkOutput("jal_repeat_bc", 64'(bc_a), 64'd6);
    lookup("jal_aligned", 32'h200, 1'b1, 32'h400);

    $display("[TB] stall freezes training");
    stall = 1'b1;
    resolveOne(1'b0, 1'b1, 32'h200, 1'b1, 32'h800, 1'b0, 32'h0);
    checkOutput("stall_redirect", 64'(bus_a.redirect_valid), 64'd0);
    checkOutput("stall_bc", 64'(bc_a), 64'd6);
    checkOutput("stall_mc", 64'(mc_a), 64'd3);
    lookup("stall_lookup", 32'h200, 1'b1, 32'h400);
    stall = 1'b0;
    idle(2);

    $display("[TB] aliasing");
    resolveOne(1'b1, 1'b0, 32'h140, 1'b1, 32'h300, 1'b0, 32'h0);
    checkOutput("alias_alloc_mc", 64'(mc_a), 64'd4);
    idle(3);
    lookup("alias_before", 32'h140, 1'b1, 32'h300);
    resolveOne(1'b0, 1'b0, 32'h140, 1'b0, 32'h0, 1'b1, 32'h300);
    checkOutput("alias_redirect_valid", 64'(bus_a.redirect_valid), 64'd1);
    checkOutput("alias_redirect_pc", 64'(bus_a.redirect_pc), 64'h144);
    checkOutput("alias_mc", 64'(mc_a), 64'd5);
    checkOutput("alias_bc", 64'(bc_a), 64'd7);
    idle(3);
    lookup("alias_after", 32'h140, 1'b0, 32'h144);

    $display("[TB] back-to-back mispredicts");
    applyStimulus(1'b1, 1'b0, 32'h10, 1'b1, 32'h500, 1'b0, 32'h0);
    step();
    checkOutput("b2b_first_pc", 64'(bus_b.redirect_pc), 64'h500);
    checkOutput("b2b_first_flush", 64'(bus_b.flush), 64'd1);
    applyStimulus(1'b1, 1'b0, 32'h20, 1'b1, 32'h601, 1'b0, 32'h0);
    step();
    bus_a.resolve_valid = 1'b0;
    checkOutput("b2b_second_valid", 64'(bus_b.redirect_valid), 64'd1);
    checkOutput("b2b_second_pc", 64'(bus_b.redirect_pc), 64'h600);
    checkOutput("b2b_flush_c2", 64'(bus_b.flush), 64'd1);
    checkOutput("sat_mc_b", 64'(mc_b), 64'd3);
    checkOutput("sat_bc_b", 64'(bc_b), 64'd3);
    checkOutput("b2b_mc_a", 64'(mc_a), 64'd7);
    checkOutput("b2b_bc_a", 64'(bc_a), 64'd9);
    step();
    checkOutput("b2b_pulse_end", 64'(bus_b.redirect_valid), 64'd0);
    checkOutput("b2b_flush_c3", 64'(bus_b.flush), 64'd1);
    step();
    checkOutput("b2b_flush_c4", 64'(bus_b.flush), 64'd1);
    checkOutput("b2b_flush_a_done", 64'(bus_a.flush), 64'd0);
    step();
    checkOutput("b2b_flush_end", 64'(bus_b.flush), 64'd0);
    lookup("b2b_entry", 32'h10, 1'b1, 32'h500);

    $display("[TB] reset mid-flush");
    resolveOne(1'b1, 1'b0, 32'h30, 1'b1, 32'h700, 1'b0, 32'h0);
    checkOutput("midrst_flush_on", 64'(bus_b.flush), 64'd1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checkOutput("midrst_flush", 64'(bus_b.flush), 64'd0);
    checkOutput("midrst_redirect_valid", 64'(bus_b.redirect_valid), 64'd0);
    checkOutput("midrst_redirect_pc", 64'(bus_b.redirect_pc), 64'h0);
    checkOutput("midrst_mc_b", 64'(mc_b), 64'd0);
    checkOutput("midrst_bc_a", 64'(bc_a), 64'd0);
    lookup("midrst_lookup", 32'h10, 1'b0, 32'h14);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
